// File: rtl/sha3_multi_scanner_dispatcher.sv
// sha3_multi_scanner_dispatcher
//   Host-side front end for NUM_SCANNERS SHA-3 scanner channels. A single job
//   is latched on start, the nonce range is split across the channels, and
//   channel capture pulses are funnelled through per-channel holding
//   registers and a round-robin arbiter into one shared show-ahead result FIFO.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   start, blobby     job strobe (honoured only while idle) and job words
//   threshold         forwarded, registered, as sc_threshold
//   idle, busy        ready-for-start / job-in-progress
//   found, hash, nonce, scanner_id, result_pop   head of result FIFO + pop
//   dropped           saturating count of captures lost this job
//   scan_count        NUM_SCANNERS * sc_scan_count, saturating
//   sc_*              per-channel scanner interface

// Per-channel 1-entry holding register. A capture loads when the register
// is empty or is being granted to the FIFO in the same cycle; otherwise the
// capture is lost and reported on drop.
module sha3_multi_scanner_dispatcher_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         cap,
  input  logic         grant,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q,
  output logic         drop
);
  logic load;
  assign load = cap && (!vld || grant);
  assign drop = cap && vld && !grant;

  always_ff @(posedge clk) begin
    if (rst || flush) vld <= 1'b0;
    else if (load)    vld <= 1'b1;
    else if (grant)   vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) q <= d;
  end
endmodule

module sha3_multi_scanner_dispatcher #(
  parameter  int NUM_SCANNERS   = 4,
  parameter  int PROPER         = 1,
  parameter  int NONCE_WORD     = ((PROPER != 0) ? 20 : 24) - 1,
  parameter  int RESULT_DEPTH   = 4,
  parameter  int STOP_ON_FIRST  = 1,
  localparam int INPUT_ELEMENTS = (PROPER != 0) ? 20 : 24,
  localparam int IDW            = (NUM_SCANNERS > 1) ? $clog2(NUM_SCANNERS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [INPUT_ELEMENTS*32-1:0]           blobby,
  input  logic [63:0]                            threshold,
  output logic                                   idle,
  output logic                                   busy,
  output logic                                   found,
  output logic [25*64-1:0]                       hash,
  output logic [31:0]                            nonce,
  output logic [IDW-1:0]                         scanner_id,
  input  logic                                   result_pop,
  output logic [15:0]                            dropped,
  output logic [31:0]                            scan_count,
  output logic [NUM_SCANNERS-1:0]                sc_start,
  output logic [NUM_SCANNERS*INPUT_ELEMENTS*32-1:0] sc_blobby,
  output logic [63:0]                            sc_threshold,
  input  logic [31:0]                            sc_scan_count,
  input  logic [NUM_SCANNERS-1:0]                sc_awaiting,
  input  logic [NUM_SCANNERS-1:0]                sc_capture,
  input  logic [NUM_SCANNERS*25*64-1:0]          sc_hash,
  input  logic [NUM_SCANNERS*32-1:0]             sc_nonce
);
  localparam int        JW   = INPUT_ELEMENTS * 32;
  localparam int        HW   = 25 * 64;
  localparam int        RW   = 32 + HW;          // {nonce, hash}
  localparam int        AW   = $clog2(RESULT_DEPTH);
  localparam bit        STOP = (STOP_ON_FIRST != 0);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    nonce;
    logic [HW-1:0]  hash;
  } res_t;

  state_t                  state_q, state_d;
  logic                    accept;
  logic [NUM_SCANNERS-1:0] seen_q;
  logic                    won_q;
  logic [IDW-1:0]          rr_q, rr_next;

  // ---------------------------------------------------------------- job fan-out
  logic [JW-1:0] lane_job [NUM_SCANNERS];
  logic [JW-1:0] blob_q   [NUM_SCANNERS];

  assign accept = (state_q == IDLE) && start;

  // Nonce base for channel i is base + i*range; the add wraps mod 2^32.
  always_comb begin
    for (int i = 0; i < NUM_SCANNERS; i++) begin
      lane_job[i] = blobby;
      lane_job[i][NONCE_WORD*32 +: 32] = blobby[NONCE_WORD*32 +: 32] + 32'(i) * sc_scan_count;
    end
  end

  // Registered on the accepted start so channels see a stable job for the
  // whole run, independent of later blobby changes.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_SCANNERS; i++) blob_q[i] <= lane_job[i];
    end
  end

  for (genvar i = 0; i < NUM_SCANNERS; i++) begin : g_blob
    assign sc_blobby[i*JW +: JW] = blob_q[i];
  end

  logic [63:0] scan_prod;
  assign scan_prod  = 64'(sc_scan_count) * 64'(NUM_SCANNERS);
  assign scan_count = (|scan_prod[63:32]) ? 32'hFFFF_FFFF : scan_prod[31:0];

  // ---------------------------------------------------------------- capture path
  logic                       fifo_wr, fifo_full, fifo_empty, pop_en, grant_en, cap_ok, flush;
  logic [NUM_SCANNERS-1:0]    cap_en, gnt, hold_vld, hold_drop;
  logic [NUM_SCANNERS*RW-1:0] cap_d, hold_q;
  logic [IDW-1:0]             gnt_id;
  logic [RW-1:0]              gnt_d;

  // Once a job has its winner, everything still arriving (including captures
  // in the winning cycle) is discarded silently.
  assign cap_ok = (state_q != IDLE) && !(STOP && (won_q || fifo_wr));
  assign cap_en = sc_capture & {NUM_SCANNERS{cap_ok}};
  assign flush  = STOP && fifo_wr;

  for (genvar i = 0; i < NUM_SCANNERS; i++) begin : g_capd
    assign cap_d[i*RW +: RW] = {sc_nonce[i*32 +: 32], sc_hash[i*HW +: HW]};
  end

  sha3_multi_scanner_dispatcher_lane #(.W(RW)) u_lane [NUM_SCANNERS-1:0] (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .cap   (cap_en),
    .grant (gnt),
    .d     (cap_d),
    .vld   (hold_vld),
    .q     (hold_q),
    .drop  (hold_drop)
  );

  // A full FIFO may still accept a write when it is popped in the same cycle.
  assign pop_en   = result_pop && !fifo_empty;
  assign grant_en = (!fifo_full || pop_en) && !(STOP && won_q);

  // Round-robin: search starts at rr_q, the channel after the last grant.
  always_comb begin : arb
    logic [IDW-1:0] idx;
    gnt     = '0;
    gnt_id  = '0;
    fifo_wr = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_SCANNERS; k++) begin
      idx = IDW'((int'(rr_q) + k) % NUM_SCANNERS);
      if (!fifo_wr && grant_en && hold_vld[idx]) begin
        fifo_wr     = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = idx;
      end
    end
  end

  assign rr_next = IDW'((int'(gnt_id) + 1) % NUM_SCANNERS);
  assign gnt_d   = hold_q[int'(gnt_id)*RW +: RW];

  logic [4:0]  drop_n;
  logic [16:0] drop_sum;
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NUM_SCANNERS; i++) drop_n = drop_n + 5'(hold_drop[i]);
  end
  assign drop_sum = {1'b0, dropped} + {12'd0, drop_n};

  // ---------------------------------------------------------------- result FIFO
  res_t        fifo_mem [RESULT_DEPTH];
  res_t        head;
  logic [AW:0] wr_ptr, rd_ptr;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr[AW-1:0]] <= {gnt_id, gnt_d};
  end

  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign found      = !fifo_empty;
  assign hash       = head.hash;
  assign nonce      = head.nonce;
  assign scanner_id = head.id;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      seen_q       <= '0;
      won_q        <= 1'b0;
      dropped      <= '0;
      rr_q         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      sc_threshold <= '0;
    end else begin
      state_q      <= state_d;
      sc_threshold <= threshold;
      if (accept) begin
        seen_q  <= '0;
        won_q   <= 1'b0;
        dropped <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
      end else begin
        if (state_q == RUN) seen_q <= seen_q | sc_awaiting;
        if (fifo_wr) begin
          won_q  <= 1'b1;
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop_en) rd_ptr <= rd_ptr + PTR_ONE;
        if (drop_n != 5'd0) dropped <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      if (fifo_wr) rr_q <= rr_next;
    end
  end

  // DRAIN also waits out a capture landing this cycle, so holding
  // registers are guaranteed empty whenever the block is idle.
  always_comb begin
    state_d  = state_q;
    sc_start = '0;
    case (state_q)
      IDLE:    if (start) state_d = LAUNCH;
      LAUNCH:  begin
        sc_start = '1;
        state_d  = RUN;
      end
      RUN:     if (&seen_q && !(|sc_awaiting)) state_d = DRAIN;
      DRAIN:   if (!(|hold_vld) && !(|cap_en)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign idle = (state_q == IDLE);
  assign busy = !idle;
endmodule

// File: tb/tb_sha3_multi_scanner_dispatcher.sv
// Directed bench for sha3_multi_scanner_dispatcher. Three instances share
// stimulus: u_a (STOP_ON_FIRST=1, depth 4), u_b (STOP_ON_FIRST=0, depth 4),
// u_c (STOP_ON_FIRST=0, depth 2). Each scenario starts from reset.
module tb_sha3_multi_scanner_dispatcher;
  localparam int N  = 4;
  localparam int IE = 20;
  localparam int NW = IE - 1;
  localparam int BW = N * IE * 32;

  logic             clk = 1'b0;
  logic             rst, start, result_pop;
  logic [IE*32-1:0] blobby;
  logic [63:0]      threshold;
  logic [31:0]      sc_scan_count;
  logic [N-1:0]     sc_awaiting, sc_capture;
  logic [N*1600-1:0] sc_hash;
  logic [N*32-1:0]  sc_nonce;

  wire [2:0]          idle, busy, found;
  wire [2:0][1599:0]  hash;
  wire [2:0][31:0]    nonce;
  wire [2:0][1:0]     scanner_id;
  wire [2:0][15:0]    dropped;
  wire [2:0][31:0]    scan_count;
  wire [2:0][N-1:0]   sc_start;
  wire [2:0][BW-1:0]  sc_blobby;
  wire [2:0][63:0]    sc_threshold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha3_multi_scanner_dispatcher u_a (
    .clk(clk), .rst(rst), .start(start), .blobby(blobby), .threshold(threshold),
    .idle(idle[0]), .busy(busy[0]), .found(found[0]), .hash(hash[0]), .nonce(nonce[0]),
    .scanner_id(scanner_id[0]), .result_pop(result_pop), .dropped(dropped[0]),
    .scan_count(scan_count[0]), .sc_start(sc_start[0]), .sc_blobby(sc_blobby[0]),
    .sc_threshold(sc_threshold[0]), .sc_scan_count(sc_scan_count), .sc_awaiting(sc_awaiting),
    .sc_capture(sc_capture), .sc_hash(sc_hash), .sc_nonce(sc_nonce));

  sha3_multi_scanner_dispatcher #(.STOP_ON_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .start(start), .blobby(blobby), .threshold(threshold),
    .idle(idle[1]), .busy(busy[1]), .found(found[1]), .hash(hash[1]), .nonce(nonce[1]),
    .scanner_id(scanner_id[1]), .result_pop(result_pop), .dropped(dropped[1]),
    .scan_count(scan_count[1]), .sc_start(sc_start[1]), .sc_blobby(sc_blobby[1]),
    .sc_threshold(sc_threshold[1]), .sc_scan_count(sc_scan_count), .sc_awaiting(sc_awaiting),
    .sc_capture(sc_capture), .sc_hash(sc_hash), .sc_nonce(sc_nonce));

  sha3_multi_scanner_dispatcher #(.STOP_ON_FIRST(0), .RESULT_DEPTH(2)) u_c (
    .clk(clk), .rst(rst), .start(start), .blobby(blobby), .threshold(threshold),
    .idle(idle[2]), .busy(busy[2]), .found(found[2]), .hash(hash[2]), .nonce(nonce[2]),
    .scanner_id(scanner_id[2]), .result_pop(result_pop), .dropped(dropped[2]),
    .scan_count(scan_count[2]), .sc_start(sc_start[2]), .sc_blobby(sc_blobby[2]),
    .sc_threshold(sc_threshold[2]), .sc_scan_count(sc_scan_count), .sc_awaiting(sc_awaiting),
    .sc_capture(sc_capture), .sc_hash(sc_hash), .sc_nonce(sc_nonce));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lw(input int k, input int lane, input int w);
    return sc_blobby[k][(lane*IE + w)*32 +: 32];
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; result_pop = 1'b0;
    sc_capture = '0; sc_awaiting = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic launch(input logic [31:0] base);
    for (int w = 0; w < IE; w++) blobby[w*32 +: 32] = 32'hB0B0_0000 + 32'(w);
    blobby[NW*32 +: 32] = base;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_cap(input int lane, input logic [31:0] n);
    sc_nonce[lane*32 +: 32] = n;
    sc_hash[lane*1600 +: 64] = {32'hABCD_0000, n};
  endtask

  task automatic pop();
    result_pop = 1'b1;
    tick();
    result_pop = 1'b0;
  endtask

  logic [31:0] nb_a [4] = '{32'h0000_0100, 32'h0000_1100, 32'h0000_2100, 32'h0000_3100};
  logic [31:0] q_c  [3] = '{32'd20, 32'd21, 32'd22};

  initial begin
    rst = 1'b1; start = 1'b0; result_pop = 1'b0; blobby = '0;
    threshold = 64'h1234_5678_9ABC_DEF0; sc_scan_count = 32'h1000;
    sc_awaiting = '0; sc_capture = '0; sc_hash = '0; sc_nonce = '0;
    tick(); tick();
    // reset values
    chk("rst_idle",  64'(idle), 64'h7);
    chk("rst_busy",  64'(busy), 64'h0);
    chk("rst_found", 64'(found), 64'h0);
    chk("rst_start", 64'(sc_start[0]), 64'h0);
    chk("rst_drop",  64'(dropped[0]), 64'h0);
    chk("rst_thr",   sc_threshold[0], 64'h0);
    rst = 1'b0;
    tick();
    chk("thr_fwd", sc_threshold[0], 64'h1234_5678_9ABC_DEF0);

    // nonce partitioning, start pulse width, scan_count
    launch(32'h0000_0100);
    chk("launch_start", 64'(sc_start[0]), 64'hF);
    chk("launch_idle",  64'(idle[0]), 64'h0);
    chk("launch_busy",  64'(busy[0]), 64'h1);
    for (int i = 0; i < N; i++) chk("nonce_base", 64'(lw(0, i, NW)), 64'(nb_a[i]));
    chk("job_word0", 64'(lw(0, 2, 0)), 64'hB0B0_0000);
    chk("scan_count", 64'(scan_count[0]), 64'h4000);
    tick();
    chk("start_one_cycle", 64'(sc_start[0]), 64'h0);
    launch(32'hDEAD_0000);
    chk("busy_start_ign",  64'(lw(0, 0, NW)), 64'h0000_0100);
    chk("busy_no_pulse",   64'(sc_start[0]), 64'h0);

    // nonce wrap and scan_count saturation
    do_reset();
    launch(32'hFFFF_F800);
    chk("wrap_lane0", 64'(lw(0, 0, NW)), 64'hFFFF_F800);
    chk("wrap_lane1", 64'(lw(0, 1, NW)), 64'h0000_0800);
    sc_scan_count = 32'h8000_0000;
    #1;
    chk("scan_sat", 64'(scan_count[0]), 64'hFFFF_FFFF);
    sc_scan_count = 32'h1000;

    // four simultaneous captures, round-robin order, 2-cycle latency
    do_reset();
    launch(32'h0);
    tick();
    sc_awaiting = '1;
    for (int i = 0; i < N; i++) set_cap(i, 32'(10 + i));
    sc_capture = '1;
    chk("rr_found_t0", 64'(found[1]), 64'h0);
    tick();
    sc_capture = '0;
    chk("rr_found_t1", 64'(found[1]), 64'h0);
    tick();
    chk("rr_found_t2", 64'(found[1]), 64'h1);
    chk("stop_all_id", 64'(scanner_id[0]), 64'h0);
    tick(); tick(); tick();
    chk("rr_dropped", 64'(dropped[1]), 64'h0);
    for (int k = 0; k < N; k++) begin
      chk("rr_id",    64'(scanner_id[1]), 64'(k));
      chk("rr_nonce", 64'(nonce[1]), 64'(10 + k));
      chk("rr_hash",  hash[1][63:0], {32'hABCD_0000, 32'(10 + k)});
      pop();
    end
    chk("rr_empty", 64'(found[1]), 64'h0);

    // depth-2 FIFO with back-pressure into the drop counter
    do_reset();
    launch(32'h0);
    tick();
    for (int c = 0; c < 4; c++) begin
      set_cap(2, 32'(20 + c));
      sc_capture = 4'b0100;
      tick();
    end
    sc_capture = '0;
    tick(); tick();
    chk("bp_found",   64'(found[2]), 64'h1);
    chk("bp_dropped", 64'(dropped[2]), 64'h1);
    chk("d4_dropped", 64'(dropped[1]), 64'h0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_nonce", 64'(nonce[2]), 64'(q_c[k]));
      chk("bp_id",    64'(scanner_id[2]), 64'h2);
      pop();
    end
    chk("bp_empty", 64'(found[2]), 64'h0);

    // stop-on-first: ch1/ch3 together, ch0 in the winning cycle
    do_reset();
    launch(32'h0);
    tick();
    sc_awaiting = '1;
    tick();
    set_cap(1, 32'd31); set_cap(3, 32'd33);
    sc_capture = 4'b1010;
    tick();
    set_cap(0, 32'd30);
    sc_capture = 4'b0001;
    tick();
    sc_capture = '0;
    chk("sof_found", 64'(found[0]), 64'h1);
    chk("sof_id",    64'(scanner_id[0]), 64'h1);
    chk("sof_nonce", 64'(nonce[0]), 64'd31);
    tick(); tick();
    chk("sof_dropped", 64'(dropped[0]), 64'h0);
    sc_awaiting = '0;
    begin
      int n = 0;
      while (!idle[0] && n < 20) begin
        tick();
        n++;
      end
    end
    chk("sof_idle",       64'(idle[0]), 64'h1);
    chk("sof_keep_found", 64'(found[0]), 64'h1);
    chk("sof_keep_id",    64'(scanner_id[0]), 64'h1);
    pop();
    chk("sof_single", 64'(found[0]), 64'h0);

    // reset mid-job with a queued result
    do_reset();
    launch(32'h0);
    tick();
    set_cap(2, 32'h55);
    sc_capture = 4'b0100;
    tick();
    sc_capture = '0;
    tick();
    chk("mid_found", 64'(found[0]), 64'h1);
    rst = 1'b1;
    tick();
    chk("mid_idle",  64'(idle[0]), 64'h1);
    chk("mid_found0", 64'(found[0]), 64'h0);
    chk("mid_start0", 64'(sc_start[0]), 64'h0);
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_relaunch", 64'(sc_start[0]), 64'hF);
    chk("mid_busy",     64'(idle[0]), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule

// File: doc/sha3_multi_scanner_dispatcher.md
Name: sha3_multi_scanner_dispatcher

Overview:
Host-facing front end that drives NUM_SCANNERS SHA-3 scanner channels from one job. It latches the job, partitions the nonce range across the channels, and collects the channels' capture pulses. It queues results in a small FIFO tagged with the channel id. It sits between the AXI control logic and the scanner instances and replaces per-scanner buffering with one shared, arbitrated result path.

Parameters:
NUM_SCANNERS, 4, number of scanner channels, 1..16
PROPER, 1, selects job width; localparam INPUT_ELEMENTS = PROPER ? 20 : 24
NONCE_WORD, INPUT_ELEMENTS-1, index of the blobby word that carries the nonce base
RESULT_DEPTH, 4, result FIFO depth, power of two, >=2
STOP_ON_FIRST, 1, 1 = only the first result accepted per job is queued; later captures are discarded

Ports:
clk  in  1  single clock for everything
rst  in  1  synchronous, active-high reset
start  in  1  job strobe, honoured only while idle
blobby  in  32 x INPUT_ELEMENTS  job words, sampled on the accepted start
threshold  in  64  registered every clock, forwarded as sc_threshold
idle  out  1  ready for start
busy  out  1  job in progress (= ~idle)
found  out  1  result FIFO non-empty
hash  out  64 x 25  head-of-FIFO hash
nonce  out  32  head-of-FIFO nonce
scanner_id  out  $clog2(NUM_SCANNERS) max 1  head-of-FIFO channel
result_pop  in  1  consume head, ignored when empty
dropped  out  16  saturating count of captures lost this job
scan_count  out  32  NUM_SCANNERS*sc_scan_count, saturating at 32'hFFFF_FFFF
sc_start  out  NUM_SCANNERS  one-cycle start pulse per channel
sc_blobby  out  NUM_SCANNERS x INPUT_ELEMENTS x 32  per-channel job
sc_threshold  out  64  buffered threshold
sc_scan_count  in  32  constant per-channel range size
sc_awaiting  in  NUM_SCANNERS  channel has results pending
sc_capture  in  NUM_SCANNERS  one-cycle result-valid pulse
sc_hash  in  NUM_SCANNERS x 25 x 64  valid with sc_capture
sc_nonce  in  NUM_SCANNERS x 32  valid with sc_capture

Behaviour:
- Reset values: state IDLE, idle=1, busy=0, sc_start=0, FIFO empty (found=0), dropped=0, holding registers empty, sc_threshold=0. Output data registers are don't-care.
- FSM has four states: IDLE, LAUNCH, RUN, DRAIN.
- IDLE:
  - start=1 latches blobby, clears the FIFO and dropped, and moves to LAUNCH on the next edge.
  - idle falls in the same cycle as that edge.
  - start while not idle is ignored.
- LAUNCH, one cycle:
  - sc_start all ones.
  - sc_blobby[i] equals the latched blobby, except word NONCE_WORD = base + i*sc_scan_count, mod 2^32 (wraps silently).
  - sc_blobby is held stable until the next accepted start.
- RUN:
  - A per-channel seen[i] bit sets when sc_awaiting[i] is observed high.
  - Move to DRAIN when all seen are set and all sc_awaiting are low.
- DRAIN:
  - Return to IDLE once all holding registers are empty; idle rises on that edge.
  - FIFO contents survive into IDLE.
- Capture path:
  - Each channel has a 1-entry holding register.
  - sc_capture[i] at cycle t loads it at edge t+1.
  - If the register is still full at the new capture, the new result is dropped and dropped increments (saturating at 16'hFFFF).
- Arbitration:
  - Round-robin over full holding registers, one FIFO write per cycle.
  - Pointer starts after the last granted channel and resets to channel 0.
  - No grant while the FIFO is full; holding registers then back-pressure into the drop counter.
- Latency: uncontested capture at t gives found=1 with the data valid at t+2.
- FIFO is show-ahead.
  - result_pop with found=1 advances the head.
  - Pop and write in the same cycle when full is legal; occupancy stays unchanged.
- STOP_ON_FIRST=1:
  - After the first FIFO write of a job, further captures are discarded and not counted in dropped.
  - Captures in the same cycle as the winner are discarded as well; the winner is the arbitration grant.
- Captures arriving in IDLE are discarded.
- rst mid-job: immediate return to reset values. Scanners are reset by the same rst.

Test Plan:
- NUM_SCANNERS=4, sc_scan_count=32'h1000, base 32'h0000_0100 -> sc_blobby[NONCE_WORD] = 0100, 1100, 2100, 3100; scan_count=32'h4000; sc_start high exactly 1 cycle.
- Base 32'hFFFF_F800, sc_scan_count=32'h1000 -> channel 1 gets 32'h0000_0800 (wrap); sc_scan_count=32'h8000_0000 -> scan_count=32'hFFFF_FFFF.
- STOP_ON_FIRST=0, channels 0..3 capture together with nonces 10,11,12,13, no pops -> FIFO order ids 0,1,2,3; found rises 2 cycles after the capture; dropped=0.
- RESULT_DEPTH=2, channel 2 captures 4 times on consecutive cycles, no pops -> FIFO holds the first 2; the holding register keeps the 3rd; dropped=1; after 3 pops the queue shows the 3rd, then empty.
- STOP_ON_FIRST=1, channels 1 and 3 capture in the same cycle, channel 0 one cycle later -> exactly one result (id 1); dropped=0; idle returns once all awaiting fall.
- rst asserted during RUN with 1 result queued -> next cycle idle=1, found=0, sc_start=0; a start on the following cycle is accepted normally.
